// File: rtl/pc_update_unit_if.sv
// Vector-fetch bus between the PC update unit and the memory address mux.
// Ports: vec_addr/vec_rd (unit -> memory), mem_byte (memory -> unit).
interface pc_update_unit_if;
  logic [31:0] vec_addr;
  logic        vec_rd;
  logic [7:0]  mem_byte;

  modport master (
    output vec_addr,
    output vec_rd,
    input  mem_byte
  );

  modport slave (
    input  vec_addr,
    input  vec_rd,
    output mem_byte
  );
endinterface

// File: rtl/pc_update_unit.sv
// PC stage: holds PC, applies branch/jump loads, saves EPC and fetches the
// exception vector byte from memory into PC.
// Ports: clk, reset (async, active-high); PC_in, pc_write, pc_write_cond,
//   br_type, alu_zero, alu_gt, exc_opc/exc_ovf/exc_div0 in; pc_out,
//   epc_out, exc_busy out; mem (master): vec_addr, vec_rd out, mem_byte in.
// Option: define PC_ALIGN_CHECK_EN to trap misaligned PC loads (vector 252).
module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_LAT  = 2,
  parameter logic [31:0] VEC_OPC  = 32'd253,
  parameter logic [31:0] VEC_OVF  = 32'd254,
  parameter logic [31:0] VEC_DIV0 = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_in,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  br_type,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_opc,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic        exc_busy,
  pc_update_unit_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    FETCH,
    LOAD
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] VEC_MIS = 32'd252;
`endif

  state_t      state;
  logic [2:0]  cnt;
  logic        cond;
  logic        load_pc;
  logic        exc_any;
  logic [31:0] vec_sel;
  logic        misalign;

  always_comb begin
    cond = 1'b0;
    case (br_type)
      2'b00: cond = alu_zero;
      2'b01: cond = !alu_zero;
      2'b10: cond = !alu_gt;
      2'b11: cond = alu_gt;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    load_pc  = pc_write | (pc_write_cond & cond);
`ifdef PC_ALIGN_CHECK_EN
    misalign = load_pc & (PC_in[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    exc_any  = exc_opc | exc_ovf | exc_div0 | misalign;
    vec_sel  = VEC_DIV0;
    if (exc_opc)
      vec_sel = VEC_OPC;
    else if (exc_ovf)
      vec_sel = VEC_OVF;
    else if (exc_div0)
      vec_sel = VEC_DIV0;
`ifdef PC_ALIGN_CHECK_EN
    else if (misalign)
      vec_sel = VEC_MIS;
`endif
  end

  // vec_addr is latched when the exception is taken and then simply held;
  // the memory side only looks at it while vec_rd is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      pc_out       <= RESET_PC;
      epc_out      <= 32'd0;
      exc_busy     <= 1'b0;
      mem.vec_addr <= 32'd0;
      mem.vec_rd   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (exc_any) begin
            state        <= SAVE;
            exc_busy     <= 1'b1;
            mem.vec_addr <= vec_sel;
          end else if (load_pc) begin
            pc_out <= PC_in;
          end
        end
        SAVE: begin
          // PC has already advanced past the faulting instruction.
          epc_out    <= pc_out - 32'd4;
          mem.vec_rd <= 1'b1;
          cnt        <= 3'd0;
          state      <= FETCH;
        end
        FETCH: begin
          if (cnt == LAT_LAST) begin
            mem.vec_rd <= 1'b0;
            cnt        <= 3'd0;
            state      <= LOAD;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        LOAD: begin
          pc_out   <= {24'b0, mem.mem_byte};
          exc_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed self-checking bench for pc_update_unit.
// Ports: none (top level).
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_in;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  br_type;
  logic        alu_zero;
  logic        alu_gt;
  logic        exc_opc;
  logic        exc_ovf;
  logic        exc_div0;
  logic [31:0] pc_out;
  logic [31:0] epc_out;
  logic        exc_busy;

  int checks   = 0;
  int failures = 0;

  pc_update_unit_if bus ();

  pc_update_unit dut (
    .clk           (clk),
    .reset         (reset),
    .PC_in         (PC_in),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .br_type       (br_type),
    .alu_zero      (alu_zero),
    .alu_gt        (alu_gt),
    .exc_opc       (exc_opc),
    .exc_ovf       (exc_ovf),
    .exc_div0      (exc_div0),
    .pc_out        (pc_out),
    .epc_out       (epc_out),
    .exc_busy      (exc_busy),
    .mem           (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    PC_in = 32'h0; pc_write = 0; pc_write_cond = 0;
    br_type = 2'b00; alu_zero = 0; alu_gt = 0;
    exc_opc = 0; exc_ovf = 0; exc_div0 = 0;
    bus.mem_byte = 8'h00;
    tick();
    checks++;
    if (pc_out !== 32'h0 || epc_out !== 32'h0 || exc_busy !== 1'b0 ||
        bus.vec_rd !== 1'b0 || bus.vec_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset pc=%h epc=%h busy=%b rd=%b va=%h want all zero",
               pc_out, epc_out, exc_busy, bus.vec_rd, bus.vec_addr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pc_write();
    PC_in = 32'h40; pc_write = 1;
    tick();
    pc_write = 0;
    checks++;
    if (pc_out !== 32'h40) begin
      failures++;
      $display("FAIL pc_write pc=%h want 00000040", pc_out);
    end
  endtask

  task automatic test_branch();
    pc_write_cond = 1;
    br_type = 2'b00; alu_zero = 0; PC_in = 32'h80;
    tick();
    checks++;
    if (pc_out !== 32'h40) begin
      failures++;
      $display("FAIL beq_not_taken pc=%h want 00000040", pc_out);
    end
    alu_zero = 1;
    tick();
    checks++;
    if (pc_out !== 32'h80) begin
      failures++;
      $display("FAIL beq_taken pc=%h want 00000080", pc_out);
    end
    br_type = 2'b11; alu_zero = 0; alu_gt = 1; PC_in = 32'h100;
    tick();
    checks++;
    if (pc_out !== 32'h100) begin
      failures++;
      $display("FAIL bgt_taken pc=%h want 00000100", pc_out);
    end
    br_type = 2'b10; PC_in = 32'h200;
    tick();
    checks++;
    if (pc_out !== 32'h100) begin
      failures++;
      $display("FAIL ble_not_taken pc=%h want 00000100", pc_out);
    end
    br_type = 2'b01; alu_gt = 0; alu_zero = 0; PC_in = 32'h24;
    tick();
    checks++;
    if (pc_out !== 32'h24) begin
      failures++;
      $display("FAIL bne_taken pc=%h want 00000024", pc_out);
    end
    pc_write_cond = 0; br_type = 2'b00;
  endtask

  task automatic test_exception_ovf();
    int busy_n = 0;
    int rd_n   = 0;
    logic [31:0] va = 32'h0;
    bus.mem_byte = 8'h9C;
    exc_ovf = 1;
    tick();
    exc_ovf = 0;
    for (int i = 0; i < 20; i++) begin
      if (exc_busy !== 1'b1) break;
      busy_n++;
      if (bus.vec_rd === 1'b1) begin
        rd_n++;
        va = bus.vec_addr;
      end
      tick();
    end
    checks++;
    if (epc_out !== 32'h20) begin
      failures++;
      $display("FAIL ovf_epc epc=%h want 00000020", epc_out);
    end
    checks++;
    if (va !== 32'd254) begin
      failures++;
      $display("FAIL ovf_vec va=%0d want 254", va);
    end
    checks++;
    if (rd_n != 2) begin
      failures++;
      $display("FAIL ovf_rd_cycles got=%0d want 2", rd_n);
    end
    checks++;
    if (busy_n != 4) begin
      failures++;
      $display("FAIL ovf_busy_cycles got=%0d want 4", busy_n);
    end
    checks++;
    if (pc_out !== 32'h9C) begin
      failures++;
      $display("FAIL ovf_pc pc=%h want 0000009c", pc_out);
    end
  endtask

  task automatic test_priority();
    logic [31:0] va = 32'h0;
    bus.mem_byte = 8'h10;
    exc_opc = 1; exc_div0 = 1; pc_write = 1; PC_in = 32'h500;
    tick();
    exc_opc = 0; exc_div0 = 0; exc_ovf = 1;
    checks++;
    if (pc_out !== 32'h9C) begin
      failures++;
      $display("FAIL prio_no_load pc=%h want 0000009c", pc_out);
    end
    tick();
    exc_ovf = 0; pc_write = 0;
    for (int i = 0; i < 20; i++) begin
      if (exc_busy !== 1'b1) break;
      if (bus.vec_rd === 1'b1) va = bus.vec_addr;
      tick();
    end
    checks++;
    if (va !== 32'd253) begin
      failures++;
      $display("FAIL prio_vec va=%0d want 253", va);
    end
    checks++;
    if (epc_out !== 32'h98) begin
      failures++;
      $display("FAIL prio_epc epc=%h want 00000098", epc_out);
    end
    checks++;
    if (pc_out !== 32'h10) begin
      failures++;
      $display("FAIL prio_pc pc=%h want 00000010", pc_out);
    end
    tick();
    checks++;
    if (exc_busy !== 1'b0 || pc_out !== 32'h10) begin
      failures++;
      $display("FAIL busy_ignored busy=%b pc=%h want 0 00000010",
               exc_busy, pc_out);
    end
  endtask

  task automatic test_wrap_and_reset_mid();
    PC_in = 32'h0; pc_write = 1;
    tick();
    pc_write = 0;
    bus.mem_byte = 8'h77;
    exc_div0 = 1;
    tick();
    exc_div0 = 0;
    tick();
    checks++;
    if (epc_out !== 32'hFFFF_FFFC || bus.vec_rd !== 1'b1 ||
        bus.vec_addr !== 32'd255) begin
      failures++;
      $display("FAIL wrap_fetch epc=%h rd=%b va=%0d want fffffffc 1 255",
               epc_out, bus.vec_rd, bus.vec_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pc_out !== 32'h0 || epc_out !== 32'h0 || exc_busy !== 1'b0 ||
        bus.vec_rd !== 1'b0 || bus.vec_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid pc=%h epc=%h busy=%b rd=%b va=%h want zero",
               pc_out, epc_out, exc_busy, bus.vec_rd, bus.vec_addr);
    end
    reset = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (exc_busy !== 1'b0 || pc_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_discard busy=%b pc=%h want 0 00000000",
               exc_busy, pc_out);
    end
  endtask

  task automatic test_align();
    logic [31:0] va = 32'h0;
    bus.mem_byte = 8'h30;
    PC_in = 32'h42; pc_write = 1;
    tick();
    pc_write = 0;
`ifdef PC_ALIGN_CHECK_EN
    checks++;
    if (pc_out === 32'h42 || exc_busy !== 1'b1) begin
      failures++;
      $display("FAIL align_trap pc=%h busy=%b want pc!=42 busy=1",
               pc_out, exc_busy);
    end
    for (int i = 0; i < 20; i++) begin
      if (exc_busy !== 1'b1) break;
      if (bus.vec_rd === 1'b1) va = bus.vec_addr;
      tick();
    end
    checks++;
    if (va !== 32'd252 || pc_out !== 32'h30) begin
      failures++;
      $display("FAIL align_vec va=%0d pc=%h want 252 00000030", va, pc_out);
    end
`else
    checks++;
    if (pc_out !== 32'h42 || exc_busy !== 1'b0 || va !== 32'h0) begin
      failures++;
      $display("FAIL misaligned_load pc=%h busy=%b want 00000042 0",
               pc_out, exc_busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pc_write();
    test_branch();
    test_exception_ovf();
    test_priority();
    test_wrap_and_reset_mid();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
